// File: rtl/health_pkg.sv
// Shared definitions for the fighter health path: health bus width, default
// timing constants, and the controller state encoding. Also used by the HUD
// health bar and the round controller.
package health_pkg;

  localparam int unsigned HEALTH_W          = 9;
  localparam int unsigned FULL_HEALTH_DEF   = 400;
  localparam int unsigned INVULN_CYCLES_DEF = 5000000;
  localparam int unsigned BLOCK_SHIFT_DEF   = 1;
  localparam int unsigned REGEN_PERIOD_DEF  = 25000000;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_KO     = 2'd2
  } health_state_e;

  // Counter width needed to hold max_val (at least 1 bit).
  function automatic int unsigned timer_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset (count -> 0)
//   clr_i       force count to 0 (highest priority)
//   load_i      load load_val_i
//   load_val_i  value to load
//   dec_i       decrement by one; holds at 0
//   zero_o      count is 0
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/player_health_ctrl.sv
// One fighter's health controller: applies hits (with block reduction and
// saturating subtract), runs a post-hit invulnerability window, flags KO and
// restores full health on round start. All outputs are registered.
// Optional feature: define HEALTH_REGEN_EN to add slow health regeneration
// while ALIVE and below full health.
// Ports:
//   clk, rst_n   game-logic clock, synchronous active-low reset
//   round_start  pulse: restore full health, clear KO/invuln
//   hit_valid    pulse: hit event with hit_damage / blocking
//   curr_health  registered health, 0..FULL_HEALTH
//   hit_ack      pulse: hit applied
//   hit_drop     pulse: hit ignored (INVULN or KO)
//   invuln, ko   state flags
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_ALIVE  | accepting hits (regen may run)
// ST_INVULN | post-hit window, hits dropped, timer counting down
// ST_KO     | health reached 0; only round_start/reset leave
module player_health_ctrl
  import health_pkg::*;
#(
  parameter int unsigned FULL_HEALTH   = FULL_HEALTH_DEF,
  parameter int unsigned INVULN_CYCLES = INVULN_CYCLES_DEF,
  parameter int unsigned BLOCK_SHIFT   = BLOCK_SHIFT_DEF,
  parameter int unsigned REGEN_PERIOD  = REGEN_PERIOD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                round_start,
  input  logic                hit_valid,
  input  logic [HEALTH_W-1:0] hit_damage,
  input  logic                blocking,
  output logic [HEALTH_W-1:0] curr_health,
  output logic                hit_ack,
  output logic                hit_drop,
  output logic                invuln,
  output logic                ko
);

  localparam logic [HEALTH_W-1:0] FULL_H = HEALTH_W'(FULL_HEALTH);

  // Loading INVULN_CYCLES-1 makes invuln high for exactly INVULN_CYCLES cycles.
  localparam int unsigned INV_LOAD = (INVULN_CYCLES > 0) ? INVULN_CYCLES - 1 : 0;
  localparam int unsigned INV_W    = timer_width(INV_LOAD);
  localparam logic [INV_W-1:0] INV_LOAD_V = INV_LOAD[INV_W-1:0];

  health_state_e       state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic                ack_q, ack_d;
  logic                drop_q, drop_d;
  logic                invuln_q, invuln_d;
  logic                ko_q, ko_d;

  logic                inv_load, inv_dec, inv_zero;
  logic                regen_tick;

  // Damage path is one bit wider so eff >= health compares without wrap.
  logic [HEALTH_W:0]   dmg_ext, eff;
  logic [HEALTH_W-1:0] hit_health;

  assign dmg_ext    = {1'b0, hit_damage};
  assign eff        = blocking ? (dmg_ext >> BLOCK_SHIFT) : dmg_ext;
  assign hit_health = (eff >= {1'b0, health_q}) ? '0 : health_q - eff[HEALTH_W-1:0];

  cycle_timer #(.W(INV_W)) u_invuln_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (round_start),
    .load_i     (inv_load),
    .load_val_i (INV_LOAD_V),
    .dec_i      (inv_dec),
    .zero_o     (inv_zero)
  );

`ifdef HEALTH_REGEN_EN
  localparam int unsigned REGEN_LOAD = (REGEN_PERIOD > 0) ? REGEN_PERIOD - 1 : 0;
  localparam int unsigned REGEN_W    = timer_width(REGEN_LOAD);
  localparam logic [REGEN_W-1:0] REGEN_LOAD_V = REGEN_LOAD[REGEN_W-1:0];

  logic regen_ok, regen_zero, regen_reload;

  assign regen_ok   = (state_q == ST_ALIVE) && (health_q != '0) && (health_q < FULL_H);
  assign regen_tick = regen_ok && regen_zero;
  // Counter sits preloaded whenever regen is not eligible, so a full period
  // always elapses after a hit, INVULN/KO exit or round start.
  assign regen_reload = !regen_ok || regen_tick || round_start || hit_valid;

  cycle_timer #(.W(REGEN_W)) u_regen_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (1'b0),
    .load_i     (regen_reload),
    .load_val_i (REGEN_LOAD_V),
    .dec_i      (regen_ok),
    .zero_o     (regen_zero)
  );
`else
  assign regen_tick = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    ack_d    = 1'b0;
    drop_d   = 1'b0;
    inv_load = 1'b0;
    inv_dec  = 1'b0;
    if (round_start) begin
      state_d  = ST_ALIVE;
      health_d = FULL_H;
    end else begin
      unique case (state_q)
        ST_ALIVE: begin
          if (hit_valid) begin
            health_d = hit_health;
            ack_d    = 1'b1;
            if (hit_health == '0) begin
              state_d = ST_KO;
            end else if (INVULN_CYCLES > 0) begin
              state_d  = ST_INVULN;
              inv_load = 1'b1;
            end
          end else if (regen_tick && (health_q < FULL_H)) begin
            health_d = health_q + 1'b1;
          end
        end
        ST_INVULN: begin
          drop_d = hit_valid;
          if (inv_zero) begin
            state_d = ST_ALIVE;
          end else begin
            inv_dec = 1'b1;
          end
        end
        ST_KO: begin
          drop_d = hit_valid;
        end
        default: begin
          state_d = ST_ALIVE;
        end
      endcase
    end
    invuln_d = (state_d == ST_INVULN);
    ko_d     = (state_d == ST_KO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_ALIVE;
      health_q <= FULL_H;
      ack_q    <= 1'b0;
      drop_q   <= 1'b0;
      invuln_q <= 1'b0;
      ko_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      ack_q    <= ack_d;
      drop_q   <= drop_d;
      invuln_q <= invuln_d;
      ko_q     <= ko_d;
    end
  end

  assign curr_health = health_q;
  assign hit_ack     = ack_q;
  assign hit_drop    = drop_q;
  assign invuln      = invuln_q;
  assign ko          = ko_q;

endmodule

// File: tb/tb_player_health_ctrl.sv
// Scoreboard bench for player_health_ctrl (INVULN_CYCLES=8, REGEN_PERIOD=4).
module tb_player_health_ctrl;

  logic       clk;
  logic       rst_n;
  logic       round_start;
  logic       hit_valid;
  logic [8:0] hit_damage;
  logic       blocking;
  logic [8:0] curr_health;
  logic       hit_ack, hit_drop, invuln, ko;

  typedef struct packed {
    logic [8:0] h;
    logic       ack;
    logic       drop;
    logic       inv;
    logic       ko;
  } obs_t;

  obs_t exp_q[$];
  obs_t e, o;
  int   checks = 0;
  int   errors = 0;

  player_health_ctrl #(
    .FULL_HEALTH   (400),
    .INVULN_CYCLES (8),
    .BLOCK_SHIFT   (1),
    .REGEN_PERIOD  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .round_start (round_start),
    .hit_valid   (hit_valid),
    .hit_damage  (hit_damage),
    .blocking    (blocking),
    .curr_health (curr_health),
    .hit_ack     (hit_ack),
    .hit_drop    (hit_drop),
    .invuln      (invuln),
    .ko          (ko)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input int h, input logic a, input logic d, input logic i, input logic k);
    obs_t r;
    r.h = 9'(h); r.ack = a; r.drop = d; r.inv = i; r.ko = k;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.h = curr_health; r.ack = hit_ack; r.drop = hit_drop; r.inv = invuln; r.ko = ko;
    return r;
  endfunction

  // Advance one clock, sample #1 after the edge, then clear pulse inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    round_start = 1'b0;
    hit_valid   = 1'b0;
    hit_damage  = '0;
    blocking    = 1'b0;
  endtask

  task automatic hit(input int dmg, input logic blk);
    hit_valid  = 1'b1;
    hit_damage = 9'(dmg);
    blocking   = blk;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exp_q.push_back(mk(400, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
               o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
    end
    rst_n = 1'b1;
    exp_q.push_back(mk(400, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_idle got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
               o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
    end
  endtask

  task automatic test_hit_invuln();
    hit(50, 1'b0);
    exp_q.push_back(mk(350, 1, 0, 1, 0));
    tick();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL hit_apply got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
               o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
    end
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) hit(50, 1'b0);
      exp_q.push_back(mk(350, 0, (k == 3), (k < 8), 0));
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL invuln_window k=%0d got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
                 k, o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
      end
    end
  endtask

  task automatic test_block_ko();
    // 350 -> 100, then blocked 150 -> eff 75 -> 25, then 30 -> 0 and KO.
    hit(250, 1'b0);
    exp_q.push_back(mk(100, 1, 0, 1, 0));
    for (int k = 1; k <= 8; k++) exp_q.push_back(mk(100, 0, 0, (k < 8), 0));
    for (int k = 0; k <= 8; k++) begin
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL to_100 k=%0d got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
                 k, o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
      end
    end
    hit(150, 1'b1);
    exp_q.push_back(mk(25, 1, 0, 1, 0));
    for (int k = 1; k <= 8; k++) exp_q.push_back(mk(25, 0, 0, (k < 8), 0));
    for (int k = 0; k <= 8; k++) begin
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL blocked_hit k=%0d got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
                 k, o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
      end
    end
    hit(30, 1'b0);
    exp_q.push_back(mk(0, 1, 0, 0, 1));
    tick();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL ko_hit got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
               o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
    end
  endtask

  task automatic test_ko_round();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) hit(50, 1'b0);
      if (k == 2) begin
        hit(50, 1'b0);
        round_start = 1'b1;
      end
      case (k)
        0:       exp_q.push_back(mk(0, 0, 1, 0, 1));
        1:       exp_q.push_back(mk(0, 0, 0, 0, 1));
        default: exp_q.push_back(mk(400, 0, 0, 0, 0));
      endcase
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ko_round k=%0d got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
                 k, o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Hit, two idle cycles leave the invuln timer at 5, then reset.
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: begin hit(20, 1'b0); exp_q.push_back(mk(380, 1, 0, 1, 0)); end
        1, 2: exp_q.push_back(mk(380, 0, 0, 1, 0));
        3: begin rst_n = 1'b0; exp_q.push_back(mk(400, 0, 0, 0, 0)); end
        4: begin rst_n = 1'b1; hit(511, 1'b0); exp_q.push_back(mk(0, 1, 0, 0, 1)); end
        default: begin round_start = 1'b1; exp_q.push_back(mk(400, 0, 0, 0, 0)); end
      endcase
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid k=%0d got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
                 k, o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Blocked damage 1 -> eff 0: still accepted, health unchanged, invuln starts.
    // Immediate second hit is dropped; exact-health damage reaches 0.
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) begin
        hit(1, 1'b1);
        exp_q.push_back(mk(400, 1, 0, 1, 0));
      end else if (k == 1) begin
        hit(10, 1'b0);
        exp_q.push_back(mk(400, 0, 1, 1, 0));
      end else if (k <= 8) begin
        exp_q.push_back(mk(400, 0, 0, (k < 8), 0));
      end else if (k == 9) begin
        hit(400, 1'b0);
        exp_q.push_back(mk(0, 1, 0, 0, 1));
      end else begin
        round_start = 1'b1;
        exp_q.push_back(mk(400, 0, 0, 0, 0));
      end
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back k=%0d got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
                 k, o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
      end
    end
  endtask

  task automatic test_regen();
    int h;
    hit(10, 1'b0);
    exp_q.push_back(mk(390, 1, 0, 1, 0));
    for (int k = 1; k <= 8; k++) exp_q.push_back(mk(390, 0, 0, (k < 8), 0));
`ifdef HEALTH_REGEN_EN
    // +1 every 4 ALIVE cycles, saturating at 400.
    for (int k = 1; k <= 44; k++) begin
      h = 390 + k / 4;
      if (h > 400) h = 400;
      exp_q.push_back(mk(h, 0, 0, 0, 0));
    end
`else
    for (int k = 1; k <= 20; k++) exp_q.push_back(mk(390, 0, 0, 0, 0));
`endif
    while (exp_q.size() > 0) begin
      if (exp_q.size() == 0) break;
      if (exp_q.size() == 9 + 0) begin end
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL regen_run got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
                 o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
      end
      if (exp_q.size() == 0) break;
    end
`ifdef HEALTH_REGEN_EN
    // Hit lands on the 4th ALIVE cycle (a tick): damage only, no +1.
    hit(10, 1'b0);
    exp_q.push_back(mk(390, 1, 0, 1, 0));
    for (int k = 1; k <= 8; k++) exp_q.push_back(mk(390, 0, 0, (k < 8), 0));
    for (int k = 1; k <= 3; k++) exp_q.push_back(mk(390, 0, 0, 0, 0));
    for (int k = 0; k < 12; k++) begin
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL regen_pre k=%0d got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
                 k, o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
      end
    end
    hit(5, 1'b0);
    exp_q.push_back(mk(385, 1, 0, 1, 0));
    exp_q.push_back(mk(385, 0, 0, 1, 0));
    for (int k = 0; k < 2; k++) begin
      tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL regen_hit_on_tick k=%0d got h=%0d ack=%b drop=%b inv=%b ko=%b exp h=%0d ack=%b drop=%b inv=%b ko=%b",
                 k, o.h, o.ack, o.drop, o.inv, o.ko, e.h, e.ack, e.drop, e.inv, e.ko);
      end
    end
`endif
    round_start = 1'b1;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    round_start = 1'b0;
    hit_valid   = 1'b0;
    hit_damage  = '0;
    blocking    = 1'b0;
    test_reset();
    test_hit_invuln();
    test_block_ko();
    test_ko_round();
    test_reset_mid();
    test_back_to_back();
    test_regen();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
